// File: rtl/raddr_gen.sv
// Strided memory address generator: latches a base/stride/length command and issues
// one request per beat, advancing on acknowledge. Define RADDR_GEN_MEMWRAP_EN to wrap addresses at DEPTH_MEM.
module raddr_gen #(
    parameter int WIDTH_DATA = 32,
    parameter int WIDTH_ADDR = 16,
    parameter int DEPTH_MEM  = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Start,
    input  logic                  I_Clr,
    input  logic [WIDTH_DATA-1:0] I_RConfig,
    input  logic [WIDTH_DATA-1:0] I_Length,
    input  logic [WIDTH_DATA-1:0] I_Stride,
    input  logic [WIDTH_DATA-1:0] I_Base,
    input  logic                  I_Ack,
    output logic                  O_Req,
    output logic                  O_We,
    output logic [WIDTH_ADDR-1:0] O_Addr,
    output logic                  O_Busy,
    output logic                  O_Done
);

    if ((DEPTH_MEM < 1) || ((DEPTH_MEM & (DEPTH_MEM - 1)) != 0)) begin : g_bad_depth
        $error("raddr_gen: DEPTH_MEM must be a power of two");
    end

`ifdef RADDR_GEN_MEMWRAP_EN
    localparam logic [WIDTH_ADDR-1:0] ADDR_MASK = WIDTH_ADDR'(DEPTH_MEM - 1);
`else
    localparam logic [WIDTH_ADDR-1:0] ADDR_MASK = '1;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH_ADDR-1:0]   addr_q;
    logic [WIDTH_ADDR-1:0]   stride_q;
    logic [WIDTH_DATA-1:0]   count_q;
    logic                    we_q;
    logic                    desc_q;
    logic [WIDTH_ADDR-1:0]   addr_next;
    logic                    last_beat;

    // Upper command/config bits carry no meaning here.
    logic unused_cfg;
    assign unused_cfg = ^{I_RConfig, I_Stride, I_Base};

    assign addr_next = (desc_q ? (addr_q - stride_q) : (addr_q + stride_q)) & ADDR_MASK;
    assign last_beat = (count_q == WIDTH_DATA'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (I_Start) state_d = (I_Length == '0) ? DONE : RUN;
            RUN:  if (I_Ack && last_beat) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (I_Clr) state_d = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            stride_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            desc_q   <= 1'b0;
        end else if (I_Clr) begin
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (I_Start) begin
                    addr_q   <= I_Base[WIDTH_ADDR-1:0] & ADDR_MASK;
                    stride_q <= I_Stride[WIDTH_ADDR-1:0];
                    count_q  <= I_Length;
                    we_q     <= I_RConfig[0];
                    desc_q   <= I_RConfig[1];
                end
                RUN: if (I_Ack) begin
                    addr_q  <= addr_next;
                    count_q <= count_q - WIDTH_DATA'(1);
                end
                default: ;
            endcase
        end
    end

    assign O_Req  = (state_q == RUN);
    assign O_We   = (state_q == RUN) && we_q;
    assign O_Addr = addr_q;
    assign O_Busy = (state_q != IDLE);
    assign O_Done = (state_q == DONE);

endmodule

// File: tb/tb_raddr_gen.sv
// Randomized self-checking bench for raddr_gen; expected addresses come from base +/- k*stride arithmetic.
module tb_raddr_gen;
    localparam int WD = 32;
    localparam int WA = 16;
`ifdef RADDR_GEN_MEMWRAP_EN
    localparam logic [WA-1:0] MASK = WA'(1024 - 1);
`else
    localparam logic [WA-1:0] MASK = '1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, clr = 1'b0, ack = 1'b0;
    logic [WD-1:0] rcfg = '0, len = '0, stride = '0, base = '0;
    logic          req, we, busy, done;
    logic [WA-1:0] addr;

    int tests = 0;
    int fails = 0;

    raddr_gen #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA), .DEPTH_MEM(1024)) dut (
        .clock(clk), .reset(rst_n), .I_Start(start), .I_Clr(clr), .I_RConfig(rcfg),
        .I_Length(len), .I_Stride(stride), .I_Base(base), .I_Ack(ack),
        .O_Req(req), .O_We(we), .O_Addr(addr), .O_Busy(busy), .O_Done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [WA-1:0] exp_addr(logic [31:0] b, logic [31:0] s, int k, bit desc);
        logic [63:0] off, a;
        off = 64'(k) * 64'(s);
        a = desc ? (64'(b) - off) : (64'(b) + off);
        return WA'(a) & MASK;
    endfunction

    // mode 0: ack always; 1: random ack plus stray starts; 2: stall 2 cycles on beat 1
    task automatic run_seq(input string name, input logic [31:0] b, input logic [31:0] s,
                           input logic [31:0] n, input bit wr, input bit desc, input int mode,
                           output int req_cycles);
        int beat = 0, cyc = 0, stalls = 0;
        logic [WA+3:0] got, want;
        bit a;
        @(negedge clk);
        start = 1'b1; base = b; stride = s; len = n; rcfg = {30'($urandom), desc, wr};
        @(negedge clk);
        start = 1'b0;
        base = $urandom; stride = $urandom; len = $urandom; rcfg = $urandom;
        while (beat < int'(n) && cyc < 400) begin
            got  = {req, we, busy, done, addr};
            want = {1'b1, wr, 1'b1, 1'b0, exp_addr(b, s, beat, desc)};
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL %s beat %0d: {req,we,busy,done,addr}=%h required %h", name, beat, got, want);
            end
            case (mode)
                0: a = 1'b1;
                1: a = 1'($urandom_range(0, 1));
                default: begin
                    a = !(beat == 1 && stalls < 2);
                    if (!a) stalls++;
                end
            endcase
            ack = a;
            start = (mode == 1) && ($urandom_range(0, 3) == 0);
            if (a) beat++;
            cyc++;
            @(negedge clk);
        end
        ack = 1'b0; start = 1'b0;
        req_cycles = cyc;
        tests++;
        if (cyc >= 400) begin
            fails++;
            $display("FAIL %s timeout: %0d cycles, required completion of %0d beats", name, cyc, n);
        end
        got = {req, we, busy, done, {WA{1'b0}}};
        want = {1'b0, 1'b0, 1'b1, 1'b1, {WA{1'b0}}};
        tests++;
        if (got[WA+3:WA] !== want[WA+3:WA]) begin
            fails++;
            $display("FAIL %s done: {req,we,busy,done}=%b required %b", name, got[WA+3:WA], want[WA+3:WA]);
        end
        @(negedge clk);
        tests++;
        if ({req, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL %s idle: {req,busy,done}=%b required 000", name, {req, busy, done});
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom); ack = 1'($urandom); base = $urandom; len = $urandom;
            @(negedge clk);
            tests++;
            if ({req, we, busy, done, addr} !== '0) begin
                fails++;
                $display("FAIL reset: outputs=%h required 0", {req, we, busy, done, addr});
            end
        end
        start = 1'b0; ack = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic_read();
        int rc;
        run_seq("basic_read", 32'h10, 32'd4, 32'd3, 1'b0, 1'b0, 0, rc);
        tests++;
        if (rc !== 3) begin
            fails++;
            $display("FAIL basic_read cycles: %0d required 3", rc);
        end
    endtask

    task automatic test_backpressure();
        int rc;
        run_seq("backpressure", 32'h10, 32'd4, 32'd3, 1'b0, 1'b0, 2, rc);
        tests++;
        if (rc !== 5) begin
            fails++;
            $display("FAIL backpressure cycles: %0d required 5", rc);
        end
    endtask

    task automatic test_desc_write();
        int rc;
        run_seq("desc_write", 32'h2, 32'd4, 32'd2, 1'b1, 1'b1, 0, rc);
    endtask

    task automatic test_memwrap();
        int rc;
        run_seq("memwrap", 32'h3FC, 32'd8, 32'd2, 1'b0, 1'b0, 0, rc);
        run_seq("stride0", 32'h1234, 32'd0, 32'd4, 1'b1, 1'b0, 1, rc);
    endtask

    task automatic test_zero_length();
        int rc;
        run_seq("zero_len", 32'h55, 32'd4, 32'd0, 1'b1, 1'b0, 0, rc);
    endtask

    task automatic test_abort(input bit use_reset);
        string nm;
        nm = use_reset ? "abort_reset" : "abort_clr";
        @(negedge clk);
        start = 1'b1; base = 32'h100; stride = 32'd2; len = 32'd8; rcfg = 32'h0;
        @(negedge clk);
        start = 1'b0; ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if ({req, addr} !== {1'b1, exp_addr(32'h100, 32'd2, k, 1'b0)}) begin
                fails++;
                $display("FAIL %s beat %0d: {req,addr}=%h required %h", nm, k, {req, addr},
                         {1'b1, exp_addr(32'h100, 32'd2, k, 1'b0)});
            end
            @(negedge clk);
        end
        start = 1'b1; len = 32'd5; base = 32'h700;
        if (use_reset) begin
            rst_n = 1'b0;
            #1;
            tests++;
            if ({req, we, busy, done, addr} !== '0) begin
                fails++;
                $display("FAIL %s async: outputs=%h required 0", nm, {req, we, busy, done, addr});
            end
        end else begin
            clr = 1'b1;
        end
        @(negedge clk);
        clr = 1'b0; start = 1'b0; ack = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({req, busy, done} !== 3'b000) begin
                fails++;
                $display("FAIL %s after %0d: {req,busy,done}=%b required 000", nm, i, {req, busy, done});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int rc;
        for (int i = 0; i < 20; i++) begin
            run_seq("random", $urandom, $urandom, 32'($urandom_range(0, 12)),
                    1'($urandom), 1'($urandom), 1, rc);
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_backpressure();
        test_desc_write();
        test_memwrap();
        test_zero_length();
        test_abort(1'b0);
        test_abort(1'b1);
        test_random();
        test_basic_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/raddr_gen.md
RADDR_GEN -- requirements
Module: raddr_gen

Interface
REQ-001 SHALL have parameter WIDTH_DATA, default 32, the width of the configuration words.
REQ-002 SHALL have parameter WIDTH_ADDR, default 16, the width of the generated memory address.
REQ-003 SHALL have parameter DEPTH_MEM, default 1024, the memory depth in words; it SHALL be a power of two.
REQ-004 SHALL have port: clock  input  1  single clock, rising-edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: I_Start  input  1  one-cycle pulse saying the configuration words are valid.
REQ-007 SHALL have port: I_Clr  input  1  synchronous abort.
REQ-008 SHALL have port: I_RConfig  input  WIDTH_DATA  command word; bit0 is write (1) or read (0); bit1 is descending stride.
REQ-009 SHALL have port: I_Length  input  WIDTH_DATA  number of accesses.
REQ-010 SHALL have port: I_Stride  input  WIDTH_DATA  address step; only the low WIDTH_ADDR bits are used.
REQ-011 SHALL have port: I_Base  input  WIDTH_DATA  first address; only the low WIDTH_ADDR bits are used.
REQ-012 SHALL have port: I_Ack  input  1  memory accepted the current request.
REQ-013 SHALL have port: O_Req  output  1  access request.
REQ-014 SHALL have port: O_We  output  1  write-enable qualifier for O_Req.
REQ-015 SHALL have port: O_Addr  output  WIDTH_ADDR  current access address.
REQ-016 SHALL have port: O_Busy  output  1  a sequence is in progress.
REQ-017 SHALL have port: O_Done  output  1  one-cycle pulse at the end of a sequence.

Function
REQ-018 SHALL implement an FSM with the states IDLE, RUN and DONE.
REQ-019 In IDLE, I_Start SHALL latch Base, Stride, Length, bit0 and bit1 into internal registers.
REQ-020 After a start with a nonzero length, the FSM SHALL enter RUN; O_Req=1 and O_Addr=Base SHALL appear the cycle after the I_Start edge, giving 1-cycle latency.
REQ-021 In RUN, O_Req SHALL stay at 1, and O_Addr and O_We SHALL stay stable until I_Ack=1.
REQ-022 Each cycle with O_Req and I_Ack both at 1 SHALL advance the address and decrement the remaining count; the next request SHALL be issued the following cycle, with no bubble cycle.
REQ-023 Address update:
  - ascending: addr + Stride;
  - descending (bit1=1): addr - Stride;
  - the result wraps modulo 2^WIDTH_ADDR, or as set by REQ-035/036.
REQ-024 An accepted access with a remaining count of 1 SHALL move the FSM to DONE; O_Req SHALL be 0 in DONE.
REQ-025 DONE SHALL last exactly one cycle, with O_Done=1, and SHALL then return to IDLE.
REQ-026 A start with Length=0 SHALL go directly to DONE, issue no request, and pulse O_Done.
REQ-027 O_Busy SHALL be 1 in RUN and in DONE, and 0 in IDLE.
REQ-028 I_Start while not in IDLE SHALL be ignored, and the latched configuration SHALL not change.
REQ-029 I_Clr SHALL force IDLE at the next edge from any state and clear the remaining count.
  - No O_Done pulse SHALL be produced.
  - I_Clr SHALL win over a simultaneous I_Start or I_Ack.
REQ-030 A Stride of 0 SHALL repeat the Base address Length times.
REQ-031 The remaining count SHALL be WIDTH_DATA bits wide and unsigned, supporting Length up to 2^WIDTH_DATA-1.

Reset
REQ-032 While reset=0, the FSM SHALL be in IDLE.
REQ-033 While reset=0, every output SHALL read 0: O_Req, O_We, O_Busy and O_Done, with O_Addr='0.
REQ-034 While reset=0, all latched registers and counters SHALL be 0; assertion mid-sequence SHALL abort immediately, with no O_Done pulse.

Configuration
REQ-035 With macro RADDR_GEN_MEMWRAP_EN defined, every generated address SHALL be reduced modulo DEPTH_MEM (masked to log2(DEPTH_MEM) bits), including the latched Base.
REQ-036 Without RADDR_GEN_MEMWRAP_EN, addresses SHALL wrap only at 2^WIDTH_ADDR, and DEPTH_MEM SHALL be unused.

Verification
REQ-037 Basic read: Base=0x10, Stride=4, Length=3, bit0=0, I_Ack=1 every cycle -> O_Addr 0x10, 0x14, 0x18 on three consecutive cycles with O_We=0, then O_Done for 1 cycle, then O_Busy=0.
REQ-038 Backpressure: same configuration as REQ-037 with I_Ack low for 2 cycles on the second beat -> O_Addr holds 0x14 for 3 cycles; the total sequence is 5 request cycles.
REQ-039 Descending write with wrap: Base=0x0002, Stride=4, bit1=1, bit0=1, Length=2, macro undefined, WIDTH_ADDR=16 -> addresses 0x0002 and 0xFFFE, with O_We=1.
REQ-040 Memory wrap, macro defined: DEPTH_MEM=1024, Base=0x3FC, Stride=8, Length=2 -> addresses 0x3FC and 0x004.
REQ-041 Zero length and abort:
  - Length=0 -> O_Done the cycle after I_Start with no O_Req.
  - Separate run with Length=8: I_Clr, or reset=0, asserted on beat 3 together with I_Start -> IDLE, no O_Done, and the new start is ignored.
